// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the ALU sweep sequencer.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Shift opcodes take the shift amount as operand2 instead of op_b.
    function automatic logic op_uses_shamt(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_seq_rbuf.sv
// Eight-entry result buffer: one synchronous write port, one combinational read port.
module alu_seq_rbuf #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [2:0]       i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [2:0]       i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [8];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Sweeps opcodes 0..NUM_OPS-1 through an external ALU, buffering each result
// and folding it into a rotate-left/XOR signature. NUM_OPS must not exceed 8.
//
// state   | meaning
// IDLE    | waiting for start; ALU inputs hold last driven values
// DRIVE   | opcode/operands for r_idx presented to the ALU
// CAPTURE | ALU result stored to buffer and signature at cycle end
// DONE    | one-cycle done pulse, then back to IDLE
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [WIDTH-1:0] i_sh_amt,
    output logic [2:0]       o_opcode,
    output logic [WIDTH-1:0] o_operand1,
    output logic [WIDTH-1:0] o_operand2,
    input  logic [WIDTH-1:0] i_result,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sig,
    input  logic [2:0]       i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_OPS - 1);

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_sig;
    logic [2:0]       r_opcode;
    logic [WIDTH-1:0] r_operand1;
    logic [WIDTH-1:0] r_operand2;
    logic             r_busy;
    logic             r_done;

    logic             w_capture;
    logic [2:0]       w_idx_nxt;
    logic [WIDTH-1:0] w_sig_nxt;

    assign w_capture = (r_state == S_CAPTURE) && !i_abort;
    assign w_idx_nxt = r_idx + 3'd1;
    assign w_sig_nxt = {r_sig[WIDTH-2:0], r_sig[WIDTH-1]} ^ i_result;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sh       <= '0;
            r_sig      <= '0;
            r_opcode   <= '0;
            r_operand1 <= '0;
            r_operand2 <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_a        <= i_op_a;
                        r_b        <= i_op_b;
                        r_sh       <= i_sh_amt;
                        r_idx      <= '0;
                        r_sig      <= '0;
                        r_opcode   <= OP_ADD;
                        r_operand1 <= i_op_a;
                        r_operand2 <= op_uses_shamt(3'd0) ? i_sh_amt : i_op_b;
                        r_busy     <= 1'b1;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_sig <= w_sig_nxt;
                        if (r_idx == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Next opcode is presented on entry to DRIVE, not one cycle later.
                            r_idx      <= w_idx_nxt;
                            r_opcode   <= w_idx_nxt;
                            r_operand2 <= op_uses_shamt(w_idx_nxt) ? r_sh : r_b;
                            r_state    <= S_DRIVE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    alu_seq_rbuf #(.WIDTH(WIDTH)) u_rbuf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_capture),
        .i_wr_addr (r_idx),
        .i_wr_data (i_result),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

    assign o_opcode   = r_opcode;
    assign o_operand1 = r_operand1;
    assign o_operand2 = r_operand2;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sig      = r_sig;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU closing the loop.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic [7:0] sh_amt = '0;
    logic [2:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic [7:0] sig;
    logic [2:0] rd_addr = '0;
    logic [7:0] rd_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        result = '0;
        case (opcode)
            3'd0: result = operand1 + operand2;
            3'd1: result = operand1 - operand2;
            3'd2: result = ~operand1;
            3'd3: result = operand1 & operand2;
            3'd4: result = operand1 | operand2;
            3'd5: result = operand1 ^ operand2;
            3'd6: result = operand1 << operand2;
            3'd7: result = operand1 >> operand2;
            default: result = '0;
        endcase
    end

    alu_sequencer #(.WIDTH(8), .NUM_OPS(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .i_sh_amt   (sh_amt),
        .o_opcode   (opcode),
        .o_operand1 (operand1),
        .o_operand2 (operand2),
        .i_result   (result),
        .o_busy     (busy),
        .o_done     (done),
        .o_sig      (sig),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle T+1 (first DRIVE cycle) with start low.
    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
        op_a = a;
        op_b = b;
        sh_amt = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int ncyc);
        ncyc = 0;
        while (!done && ncyc < limit) begin
            tick();
            ncyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({opcode, operand1, operand2, busy, done, sig} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got op=%0d o1=%0d o2=%0d busy=%0b done=%0b sig=%0d, want all 0",
                     opcode, operand1, operand2, busy, done, sig);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_buf[%0d]: got %0d want 0", i, rd_data);
            end
        end
        tick();
    endtask

    task automatic test_basic_run();
        logic [7:0] exp [8];
        int ncyc;
        exp = '{8'd75, 8'd25, 8'd205, 8'd16, 8'd59, 8'd43, 8'd200, 8'd12};
        pulse_start(8'd50, 8'd25, 8'd2);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || opcode !== 3'(k / 2)) begin
                n_fail++;
                $display("FAIL basic_wave c%0d: got busy=%0b done=%0b op=%0d want 1 0 %0d",
                         k + 1, busy, done, opcode, k / 2);
            end
            n_checks++;
            if (operand1 !== 8'd50 || operand2 !== ((k / 2 >= 6) ? 8'd2 : 8'd25)) begin
                n_fail++;
                $display("FAIL basic_operands c%0d: got %0d %0d", k + 1, operand1, operand2);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_t17: got done=%0b busy=%0b want 1 0", done, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || opcode !== 3'd7 || operand1 !== 8'd50 || operand2 !== 8'd2) begin
            n_fail++;
            $display("FAIL basic_after_done: got done=%0b op=%0d o1=%0d o2=%0d want 0 7 50 2",
                     done, opcode, operand1, operand2);
        end
        n_checks++;
        if (sig !== 8'hB3) begin
            n_fail++;
            $display("FAIL basic_sig: got %h want b3", sig);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_buf[%0d]: got %0d want %0d", i, rd_data, exp[i]);
            end
        end
        tick();
        // Second pattern; the signature must restart from zero.
        exp = '{8'h2C, 8'hB4, 8'h0F, 8'h30, 8'hFC, 8'hCC, 8'h80, 8'h1E};
        pulse_start(8'hF0, 8'h3C, 8'd3);
        wait_done(40, ncyc);
        n_checks++;
        if (ncyc !== 16) begin
            n_fail++;
            $display("FAIL pattern2_latency: got %0d cycles want 16", ncyc);
        end
        tick();
        n_checks++;
        if (sig !== 8'h12) begin
            n_fail++;
            $display("FAIL pattern2_sig: got %h want 12", sig);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== exp[i]) begin
                n_fail++;
                $display("FAIL pattern2_buf[%0d]: got %h want %h", i, rd_data, exp[i]);
            end
        end
        tick();
    endtask

    task automatic test_operand_change();
        logic [7:0] exp [8];
        int ncyc;
        exp = '{8'd75, 8'd25, 8'd205, 8'd16, 8'd59, 8'd43, 8'd200, 8'd12};
        do_reset();
        pulse_start(8'd50, 8'd25, 8'd2);
        for (int k = 1; k < 5; k++) tick();
        op_a = 8'd0;
        op_b = 8'd99;
        sh_amt = 8'd7;
        wait_done(40, ncyc);
        n_checks++;
        if (ncyc !== 12) begin
            n_fail++;
            $display("FAIL change_latency: got %0d more cycles want 12", ncyc);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== exp[i]) begin
                n_fail++;
                $display("FAIL change_buf[%0d]: got %0d want %0d", i, rd_data, exp[i]);
            end
        end
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] exp [8];
        int dones;
        exp = '{8'd75, 8'd25, 8'd205, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_reset();
        pulse_start(8'd50, 8'd25, 8'd2);
        for (int k = 1; k < 8; k++) tick();
        n_checks++;
        if (opcode !== 3'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup: got op=%0d busy=%0b want 3 1", opcode, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || opcode !== 3'd3) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%0b done=%0b op=%0d want 0 0 3", busy, done, opcode);
        end
        n_checks++;
        if (sig !== 8'hD2) begin
            n_fail++;
            $display("FAIL abort_sig: got %h want d2", sig);
        end
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", dones);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== exp[i]) begin
                n_fail++;
                $display("FAIL abort_buf[%0d]: got %0d want %0d", i, rd_data, exp[i]);
            end
        end
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_beats_start: got busy=%0b want 0", busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int dones;
        int ncyc;
        do_reset();
        op_a = 8'd50;
        op_b = 8'd25;
        sh_amt = 8'd2;
        start = 1'b1;
        dones = 0;
        tick();
        for (int c = 1; c <= 17; c++) begin
            if (done === 1'b1) dones++;
            n_checks++;
            if (busy !== (c <= 16) || done !== (c == 17)) begin
                n_fail++;
                $display("FAIL b2b_c%0d: got busy=%0b done=%0b", c, busy, done);
            end
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_start_ignored: got busy=%0b done=%0b want 0 0", busy, done);
        end
        for (int k = 0; k < 5; k++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d want 1", dones);
        end
        pulse_start(8'd1, 8'd2, 8'd1);
        wait_done(40, ncyc);
        n_checks++;
        if (ncyc !== 16) begin
            n_fail++;
            $display("FAIL b2b_rerun_latency: got %0d want 16", ncyc);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int active;
        int ncyc;
        pulse_start(8'd50, 8'd25, 8'd2);
        for (int k = 1; k < 9; k++) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({opcode, operand1, operand2, busy, done, sig} !== 29'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got op=%0d o1=%0d o2=%0d busy=%0b done=%0b sig=%0d",
                     opcode, operand1, operand2, busy, done, sig);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== 8'd0) begin
                n_fail++;
                $display("FAIL midreset_buf[%0d]: got %0d want 0", i, rd_data);
            end
        end
        active = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) active++;
        end
        n_checks++;
        if (active !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d active cycles want 0", active);
        end
        pulse_start(8'd50, 8'd25, 8'd2);
        wait_done(40, ncyc);
        n_checks++;
        if (ncyc !== 16) begin
            n_fail++;
            $display("FAIL midreset_rerun_latency: got %0d want 16", ncyc);
        end
        tick();
        rd_addr = 3'd6;
        #1;
        n_checks++;
        if (rd_data !== 8'd200 || sig !== 8'hB3) begin
            n_fail++;
            $display("FAIL midreset_rerun_data: got buf6=%0d sig=%h want 200 b3", rd_data, sig);
        end
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_basic_run();
        test_operand_change();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
